// File: rtl/poly_voice_alloc.sv
// poly_voice_alloc: sequential polyphonic voice allocator.
// Converts note-on / note-off / all-off strobes into per-voice gate, note and
// velocity registers. One voice is examined per SCAN cycle, and the result is
// applied in COMMIT. A one-entry pending buffer holds an event that arrives
// while the allocator is busy.
// Optional feature macro: VOICE_STEAL_EN. When it is defined, the oldest voice
// is stolen if no voice is free or matching. When it is undefined, such a
// note-on is discarded and overflow is set.
module poly_voice_alloc #(
  parameter int VOICES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                note_on,
  input  logic                note_off,
  input  logic                all_off,
  input  logic [6:0]          note,
  input  logic [6:0]          velocity,
  output logic [VOICES-1:0]   gate,
  output logic [7*VOICES-1:0] voice_note,
  output logic [7*VOICES-1:0] voice_vel,
  output logic                busy,
  output logic                overflow
);
  localparam int IW = $clog2(VOICES);
  localparam logic [IW-1:0] LAST = IW'(VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2,
    S_REGATE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [VOICES-1:0] gate_q, gate_d;
  logic [6:0]        note_q [VOICES];
  logic [6:0]        note_d [VOICES];
  logic [6:0]        vel_q  [VOICES];
  logic [6:0]        vel_d  [VOICES];
  logic [IW-1:0]     age_q  [VOICES];
  logic [IW-1:0]     age_d  [VOICES];
  logic              ev_on_q, ev_on_d;
  logic [6:0]        ev_note_q, ev_note_d, ev_vel_q, ev_vel_d;
  logic              pend_valid_q, pend_valid_d, pend_on_q, pend_on_d;
  logic [6:0]        pend_note_q, pend_note_d, pend_vel_q, pend_vel_d;
  logic [IW-1:0]     scan_idx_q, scan_idx_d;
  logic              match_found_q, match_found_d, free_found_q, free_found_d;
  logic [IW-1:0]     match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic [IW-1:0]     old_idx_q, old_idx_d, regate_idx_q, regate_idx_d;
  logic              busy_q, busy_d, overflow_q, overflow_d;
  logic              in_valid_s, in_on_s, alloc_s;
  logic [IW-1:0]     k_s;

  // Next-state logic: event intake, scan, commit, regate and all_off override.
  always_comb begin
    state_d       = state_q;
    gate_d        = gate_q;
    note_d        = note_q;
    vel_d         = vel_q;
    age_d         = age_q;
    ev_on_d       = ev_on_q;
    ev_note_d     = ev_note_q;
    ev_vel_d      = ev_vel_q;
    pend_valid_d  = pend_valid_q;
    pend_on_d     = pend_on_q;
    pend_note_d   = pend_note_q;
    pend_vel_d    = pend_vel_q;
    scan_idx_d    = scan_idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_idx_d     = old_idx_q;
    regate_idx_d  = regate_idx_q;
    overflow_d    = overflow_q;
    k_s           = old_idx_q;
    alloc_s       = 1'b0;
    // A zero-velocity note-on is a note-off; note-on wins a simultaneous note-off.
    in_valid_s    = note_on | note_off;
    in_on_s       = note_on & (velocity != 7'd0);

    if (all_off) begin
      state_d      = S_IDLE;
      gate_d       = {VOICES{1'b0}};
      pend_valid_d = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      // An event that arrives while busy goes to the buffer, or it is dropped when the buffer is full.
      if ((state_q != S_IDLE) && in_valid_s) begin
        if (pend_valid_q) begin
          overflow_d = 1'b1;
        end else begin
          pend_valid_d = 1'b1;
          pend_on_d    = in_on_s;
          pend_note_d  = note;
          pend_vel_d   = velocity;
        end
      end else begin
        overflow_d = overflow_q;
      end

      case (state_q)
        S_IDLE: begin
          if (pend_valid_q || in_valid_s) begin
            state_d       = S_SCAN;
            scan_idx_d    = {IW{1'b0}};
            match_found_d = 1'b0;
            free_found_d  = 1'b0;
            match_idx_d   = {IW{1'b0}};
            free_idx_d    = {IW{1'b0}};
            old_idx_d     = {IW{1'b0}};
            if (pend_valid_q) begin
              // Pending entry goes first; a same-cycle strobe refills the freed slot.
              ev_on_d      = pend_on_q;
              ev_note_d    = pend_note_q;
              ev_vel_d     = pend_vel_q;
              pend_valid_d = in_valid_s;
              pend_on_d    = in_on_s;
              pend_note_d  = note;
              pend_vel_d   = velocity;
            end else begin
              ev_on_d   = in_on_s;
              ev_note_d = note;
              ev_vel_d  = velocity;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SCAN: begin
          if (!match_found_q && gate_q[scan_idx_q] && (note_q[scan_idx_q] == ev_note_q)) begin
            match_found_d = 1'b1;
            match_idx_d   = scan_idx_q;
          end else begin
            match_found_d = match_found_q;
          end
          if (!free_found_q && !gate_q[scan_idx_q]) begin
            free_found_d = 1'b1;
            free_idx_d   = scan_idx_q;
          end else begin
            free_found_d = free_found_q;
          end
          if (age_q[scan_idx_q] == LAST) begin
            old_idx_d = scan_idx_q;
          end else begin
            old_idx_d = old_idx_q;
          end
          if (scan_idx_q == LAST) begin
            state_d = S_COMMIT;
          end else begin
            scan_idx_d = scan_idx_q + 1'b1;
          end
        end
        S_COMMIT: begin
          state_d = S_IDLE;
          if (ev_on_q) begin
            alloc_s = 1'b1;
            if (match_found_q) begin
              k_s = match_idx_q;
            end else if (free_found_q) begin
              k_s = free_idx_q;
            end else begin
`ifdef VOICE_STEAL_EN
              k_s = old_idx_q;
`else
              alloc_s    = 1'b0;
              overflow_d = 1'b1;
`endif
            end
            if (alloc_s) begin
              note_d[k_s] = ev_note_q;
              vel_d[k_s]  = ev_vel_q;
              for (int j = 0; j < VOICES; j++) begin
                if (age_q[j] < age_q[k_s]) begin
                  age_d[j] = age_q[j] + 1'b1;
                end else begin
                  age_d[j] = age_q[j];
                end
              end
              age_d[k_s] = {IW{1'b0}};
              if (gate_q[k_s]) begin
                // Drop the gate for one cycle so the envelope sees a fresh rising edge.
                gate_d[k_s]  = 1'b0;
                regate_idx_d = k_s;
                state_d      = S_REGATE;
              end else begin
                gate_d[k_s] = 1'b1;
              end
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            // Release every held copy of the note; the note and velocity stay for the release phase.
            for (int j = 0; j < VOICES; j++) begin
              if (gate_q[j] && (note_q[j] == ev_note_q)) begin
                gate_d[j] = 1'b0;
              end else begin
                gate_d[j] = gate_q[j];
              end
            end
          end
        end
        S_REGATE: begin
          gate_d[regate_idx_q] = 1'b1;
          state_d              = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      gate_q        <= {VOICES{1'b0}};
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= 7'd0;
        vel_q[i]  <= 7'd0;
        age_q[i]  <= IW'(i);
      end
      ev_on_q       <= 1'b0;
      ev_note_q     <= 7'd0;
      ev_vel_q      <= 7'd0;
      pend_valid_q  <= 1'b0;
      pend_on_q     <= 1'b0;
      pend_note_q   <= 7'd0;
      pend_vel_q    <= 7'd0;
      scan_idx_q    <= {IW{1'b0}};
      match_found_q <= 1'b0;
      match_idx_q   <= {IW{1'b0}};
      free_found_q  <= 1'b0;
      free_idx_q    <= {IW{1'b0}};
      old_idx_q     <= {IW{1'b0}};
      regate_idx_q  <= {IW{1'b0}};
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      gate_q        <= gate_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      age_q         <= age_d;
      ev_on_q       <= ev_on_d;
      ev_note_q     <= ev_note_d;
      ev_vel_q      <= ev_vel_d;
      pend_valid_q  <= pend_valid_d;
      pend_on_q     <= pend_on_d;
      pend_note_q   <= pend_note_d;
      pend_vel_q    <= pend_vel_d;
      scan_idx_q    <= scan_idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_idx_q     <= old_idx_d;
      regate_idx_q  <= regate_idx_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
    end
  end

  assign gate     = gate_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

  for (genvar i = 0; i < VOICES; i++) begin : g_pack
    assign voice_note[7*i +: 7] = note_q[i];
    assign voice_vel[7*i +: 7]  = vel_q[i];
  end
endmodule

// File: doc/poly_voice_alloc.md
# poly_voice_alloc

Polyphonic voice allocator between `midi_in` and the per-voice VCO/ADSR/VCA chains. Turns note-on/note-off strobes into per-voice gate, note and velocity registers, so the mono `GATEreg`/`NOTEreg` pair can be replaced by VOICES parallel voices. Allocation is sequential: it scans one voice per cycle and commits the result. A one-entry pending buffer absorbs MIDI events that arrive while a scan is running.

## Interface
- VOICES, 4, number of voices (2..8)
- clk  in  1  system clock (50 MHz PLL domain)
- rst_n  in  1  asynchronous active-low reset
- note_on  in  1  one-cycle strobe; note/velocity valid
- note_off  in  1  one-cycle strobe; note valid
- all_off  in  1  one-cycle strobe; release all voices
- note  in  7  MIDI note number
- velocity  in  7  MIDI velocity
- gate  out  VOICES  per-voice gate, bit i = voice i
- voice_note  out  7*VOICES  voice i at [7i+6:7i]
- voice_vel  out  7*VOICES  voice i at [7i+6:7i]
- busy  out  1  high while the FSM is not in IDLE
- overflow  out  1  sticky; set when an event is dropped

## Operation
- Reset values: gate=0, voice_note=0, voice_vel=0, busy=0, overflow=0. Pending buffer is empty. FSM is in IDLE. Age rank of voice i = i.
- A note_on with velocity==0 is treated as a note_off.
- If note_on and note_off arrive in the same cycle, note_on wins and note_off is discarded. overflow is not set.
- FSM states:
  - IDLE: takes the pending entry if one exists, otherwise the input strobe. Latches it and moves to SCAN.
  - SCAN: stays VOICES cycles and examines voice i in cycle i.
  - COMMIT: applies the result.
  - REGATE: sets the gate for a retriggered voice.
- Note-on selection, in priority order:
  1. A voice with gate=1 and the same note (retrigger).
  2. The lowest-index voice with gate=0.
  3. The voice with the highest age rank (steal; see Configuration).
- Note-on commit:
  - The chosen voice k gets voice_note and voice_vel written.
  - If gate[k] was 0: gate[k]=1 and the FSM returns to IDLE.
  - If gate[k] was 1: gate[k]=0 for one cycle, then REGATE sets gate[k]=1. This gives the ADSR a fresh rising edge.
- Age update on each allocation to k: every voice with age < age_k increments, then age_k=0. Ages stay a permutation of 0..VOICES-1.
- Note-off commit: every voice with gate=1 and a matching note gets gate=0. note and vel are kept for the release phase. An unheld note causes no change.
- all_off: highest priority, acts in any state. Next cycle gate=0, the FSM is in IDLE, the pending buffer is empty and overflow=0. Ages are unchanged.
- Event arriving while busy=1: stored in the pending buffer. If the buffer is already full, the event is dropped and overflow=1.

## Timing
- An event is accepted at edge E0 in IDLE; busy=1 after E0.
- SCAN covers edges E1..E_VOICES. COMMIT is at E_(VOICES+1).
- Free voice: gate is visible after E_(VOICES+1), and busy=0 after that same edge.
- Retrigger or steal: gate is low after E_(VOICES+1) and high after E_(VOICES+2). busy=0 after E_(VOICES+2).
- Back-to-back events: a pending event is taken in the first IDLE cycle, so it adds one cycle of IDLE.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronous reset).

## Configuration
- VOICE_STEAL_EN defined: when no voice is free and none matches, the oldest voice is stolen and retriggered as described above.
- VOICE_STEAL_EN undefined: such a note_on is discarded in COMMIT. No register changes, ages are unchanged, overflow=1.

## Test plan
- VOICES=4, note_on 60/100 → after 5 edges gate=0001, voice_note[0]=60, voice_vel[0]=100, busy=0.
- note_on 60,62,64 then note_off 62 → gate=0111, then gate=0101; voice_note[1] stays 62.
- note_on 60 twice → second commit gives gate[0] low for 1 cycle then high; gate[1] stays 0.
- 5 note_ons 60..64 with VOICE_STEAL_EN → voice 0 takes 64 with a regate pulse. Without the macro → gate=1111, notes unchanged, overflow=1.
- Three strobes within 3 cycles → the second is queued and processed; the third is dropped, overflow=1. A following all_off → gate=0000, overflow=0.
- note_on with velocity 0 for a held note → behaves as note_off. rst_n pulse mid-SCAN → all outputs 0 and busy=0 with no clock edge.
